// File: rtl/markov_second_learn_pkg.sv
// Shared constants, entry layout and state encoding for the second-order
// Markov learn and merge stages.
package markov_second_learn_pkg;

  localparam int MSL_NOTE_W  = 7;
  localparam int MSL_CNT_W   = 8;
  localparam int MSL_DEPTH   = 64;
  localparam int MSL_ADDR_W  = $clog2(MSL_DEPTH);
  localparam int MSL_ENTRY_W = 3*MSL_NOTE_W + MSL_CNT_W;

  // Entry layout, MSB first: {prev2, prev1, next, count}
  localparam int MSL_OFF_COUNT = 0;
  localparam int MSL_OFF_NEXT  = MSL_CNT_W;
  localparam int MSL_OFF_PREV1 = MSL_CNT_W + MSL_NOTE_W;
  localparam int MSL_OFF_PREV2 = MSL_CNT_W + 2*MSL_NOTE_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_NOTE = 3'd1,
    ST_SEARCH    = 3'd2,
    ST_INCREMENT = 3'd3,
    ST_APPEND    = 3'd4,
    ST_FINISH    = 3'd5
  } learn_state_e;

endpackage

// File: rtl/markov_second_learn_if.sv
// Note-stream handshake, list read port and status bundle of the learn stage.
interface markov_second_learn_if
  import markov_second_learn_pkg::*;
#(
  parameter int NOTE_W = MSL_NOTE_W,
  parameter int CNT_W  = MSL_CNT_W,
  parameter int ADDR_W = MSL_ADDR_W
);
  localparam int ENTRY_W = 3*NOTE_W + CNT_W;

  logic                start;
  logic                note_valid;
  logic                note_ready;
  logic [NOTE_W-1:0]   note_data;
  logic                note_last;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ENTRY_W-1:0]  rd_entry;
  logic [ADDR_W:0]     entry_count;
  logic                busy;
  logic                done;
  logic                overflow;

  modport master (
    output start, note_valid, note_data, note_last, rd_addr,
    input  note_ready, rd_entry, entry_count, busy, done, overflow
  );

  modport slave (
    input  start, note_valid, note_data, note_last, rd_addr,
    output note_ready, rd_entry, entry_count, busy, done, overflow
  );

endinterface

// File: rtl/markov_list_ram.sv
// Transition-list storage: one write port and two registered read ports
// (external read port and internal search port). Read-during-write returns old data.
module markov_list_ram
  import markov_second_learn_pkg::*;
#(
  parameter int WIDTH  = MSL_ENTRY_W,
  parameter int DEPTH  = MSL_DEPTH,
  parameter int ADDR_W = MSL_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [WIDTH-1:0]  o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [WIDTH-1:0]  o_rdata_b
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata_a;
  logic [WIDTH-1:0] r_rdata_b;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      r_rdata_a <= r_mem[i_raddr_a];
      r_rdata_b <= r_mem[i_raddr_b];
    end
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/markov_second_learn.sv
// Second-order Markov training stage: builds a list of (prev2, prev1, next, count)
// transitions from one note stream, one list entry compared per cycle.
module markov_second_learn
  import markov_second_learn_pkg::*;
#(
  parameter int NOTE_W = MSL_NOTE_W,
  parameter int CNT_W  = MSL_CNT_W,
  parameter int DEPTH  = MSL_DEPTH,
  parameter int ADDR_W = MSL_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  markov_second_learn_if.slave  bus
);

  localparam int ENTRY_W = 3*NOTE_W + CNT_W;
  localparam int KEY_W   = 3*NOTE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);

  learn_state_e         r_state;
  learn_state_e         w_next;
  logic [1:0]           r_hv;
  logic [NOTE_W-1:0]    r_h1;
  logic [NOTE_W-1:0]    r_h2;
  logic [KEY_W-1:0]     r_key;
  logic                 r_last;
  logic [ADDR_W-1:0]    r_idx;
  logic [CNT_W-1:0]     r_hit_cnt;
  logic [ADDR_W:0]      r_entry_count;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overflow;

  logic                 w_xfer;
  logic                 w_match;
  logic                 w_search_end;
  logic                 w_full;
  logic                 w_we;
  logic [ADDR_W-1:0]    w_waddr;
  logic [ENTRY_W-1:0]   w_wdata;
  logic [ADDR_W-1:0]    w_srch_addr;
  logic [ENTRY_W-1:0]   w_srch_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  assign w_xfer       = bus.note_valid && bus.note_ready;
  assign w_match      = (w_srch_data[ENTRY_W-1 -: KEY_W] == r_key);
  assign w_search_end = ({1'b0, r_idx} == (r_entry_count - (ADDR_W+1)'(1)));
  assign w_full       = (r_entry_count == DEPTH_C);

  // The search port runs one address ahead so entry[idx] is ready in each SEARCH cycle.
  assign w_srch_addr  = (r_state == ST_SEARCH) ? r_idx + ADDR_W'(1) : '0;

  markov_list_ram #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (bus.rd_addr),
    .o_rdata_a (bus.rd_entry),
    .i_raddr_b (w_srch_addr),
    .o_rdata_b (w_srch_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = r_idx;
    w_wdata = {r_key, sat_inc(r_hit_cnt)};
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next = ST_WAIT_NOTE;
      end
      ST_WAIT_NOTE: begin
        if (w_xfer) begin
          if (r_hv < 2'd2)                w_next = bus.note_last ? ST_FINISH : ST_WAIT_NOTE;
          else if (r_entry_count == '0)   w_next = ST_APPEND;
          else                            w_next = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (w_match)           w_next = ST_INCREMENT;
        else if (w_search_end) w_next = ST_APPEND;
      end
      ST_INCREMENT: begin
        w_we   = 1'b1;
        w_next = r_last ? ST_FINISH : ST_WAIT_NOTE;
      end
      ST_APPEND: begin
        if (!w_full) begin
          w_we    = 1'b1;
          w_waddr = r_entry_count[ADDR_W-1:0];
          w_wdata = {r_key, CNT_W'(1)};
        end
        w_next = r_last ? ST_FINISH : ST_WAIT_NOTE;
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hv          <= '0;
      r_entry_count <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.start) begin
        r_hv          <= '0;
        r_entry_count <= '0;
        r_overflow    <= 1'b0;
        r_done        <= 1'b0;
        r_busy        <= 1'b1;
      end
      if (w_xfer && r_hv < 2'd2) r_hv <= r_hv + 2'd1;
      if (r_state == ST_APPEND) begin
        if (w_full) r_overflow    <= 1'b1;
        else        r_entry_count <= r_entry_count + (ADDR_W+1)'(1);
      end
      if (r_state == ST_FINISH) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  // History and search key hold no meaning until hv reaches 2, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_h2   <= r_h1;
      r_h1   <= bus.note_data;
      r_key  <= {r_h2, r_h1, bus.note_data};
      r_last <= bus.note_last;
      r_idx  <= '0;
    end else if (r_state == ST_SEARCH) begin
      r_hit_cnt <= w_srch_data[CNT_W-1:0];
      if (!w_match) r_idx <= r_idx + ADDR_W'(1);
    end
  end

  assign bus.note_ready  = (r_state == ST_WAIT_NOTE);
  assign bus.entry_count = r_entry_count;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.overflow    = r_overflow;

endmodule
